// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the RISC-V memory responder slice.
package riscv_mem_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 1;
  localparam logic [31:0] MMIO_BASE_DEF   = 32'h1000_0000;

  localparam logic [31:0] CONSOLE_OFF = 32'h0000_0000;
  localparam logic [31:0] HALT_OFF    = 32'h0000_0004;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/riscv_mem_sram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module riscv_mem_sram
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/riscv_mem_responder.sv
// Wait-state memory responder: RAM, console/halt MMIO and illegal-access trapping
// behind a valid/ready request handshake.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        halt,
  output logic        fault
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [29:0]      r_word;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             r_instr;

  logic [31:0]      w_byte_addr;
  logic             w_ram_hit;
  logic             w_con_hit;
  logic             w_halt_hit;
  logic             w_illegal;
  logic             w_last;
  logic             w_ram_we;
  logic [AW-1:0]    w_sram_addr;
  logic [31:0]      w_sram_rdata;
  logic [31:0]      w_rdata;
  logic             w_unused_lsbs;

  assign w_unused_lsbs = ^mem_addr[1:0];

  // Address decode on the latched request.
  assign w_byte_addr = {r_word, 2'b00};
  assign w_ram_hit   = {1'b0, w_byte_addr} < RAM_BYTES;
  assign w_con_hit   = !w_ram_hit && !r_instr && (w_byte_addr == MMIO_BASE + CONSOLE_OFF);
  assign w_halt_hit  = !w_ram_hit && !r_instr && (w_byte_addr == MMIO_BASE + HALT_OFF);
  assign w_illegal   = !w_ram_hit && !w_con_hit && !w_halt_hit;

  // Final WAIT cycle with the request still held: the response edge comes next.
  assign w_last   = (r_state == WAIT) && (r_cnt == '0) && mem_valid;
  assign w_ram_we = reset && w_last && w_ram_hit;

  // The RAM read is launched on the sampling edge so data is ready even with zero wait states.
  assign w_sram_addr = (r_state == IDLE) ? mem_addr[AW+1:2] : r_word[AW-1:0];

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit)       w_rdata = w_sram_rdata;
    else if (w_con_hit)  w_rdata = 32'h0000_0001;
    else if (w_halt_hit) w_rdata = {31'b0, halt};
  end

  riscv_mem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_sram (
    .clk   (clk),
    .addr  (w_sram_addr),
    .we    (w_ram_we ? r_wstrb : 4'b0000),
    .wdata (r_wdata),
    .rdata (w_sram_rdata)
  );

  // A zero-wait access still spends its single read cycle in WAIT with the counter at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_word        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_instr       <= 1'b0;
      mem_ready     <= 1'b0;
      mem_rdata     <= '0;
      console_valid <= 1'b0;
      console_data  <= '0;
      halt          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      mem_ready     <= 1'b0;
      console_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mem_valid) begin
            r_word  <= mem_addr[31:2];
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_instr <= mem_instr;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_valid) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state   <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= w_rdata;
            if (w_con_hit && r_wstrb[0]) begin
              console_valid <= 1'b1;
              console_data  <= r_wdata[7:0];
            end
            if (w_halt_hit && (r_wstrb != 4'b0000)) halt <= 1'b1;
            if (w_illegal) fault <= 1'b1;
          end
        end
        RESP:    r_state <= RECOVER;
        RECOVER: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Directed and randomized bench for riscv_mem_responder: two instances (1 and 3 wait states)
// checked against a byte-level memory/MMIO reference model.
module tb_riscv_mem_responder;

  localparam logic [31:0] MMIO = 32'h1000_0000;
  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst_n [2];
  logic        v     [2];
  logic        ins   [2];
  logic [31:0] ad    [2];
  logic [31:0] wd    [2];
  logic [3:0]  ws    [2];
  logic        rdy   [2];
  logic [31:0] rd    [2];
  logic        cv    [2];
  logic [7:0]  cd    [2];
  logic        hl    [2];
  logic        ft    [2];

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem   [2][DEPTH];
  logic [3:0]  m_known [2][DEPTH];
  logic        m_halt  [2];
  logic        m_fault [2];
  logic [7:0]  m_cd    [2];

  riscv_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(rst_n[0]), .mem_valid(v[0]), .mem_instr(ins[0]), .mem_addr(ad[0]),
    .mem_wdata(wd[0]), .mem_wstrb(ws[0]), .mem_ready(rdy[0]), .mem_rdata(rd[0]),
    .console_valid(cv[0]), .console_data(cd[0]), .halt(hl[0]), .fault(ft[0])
  );

  riscv_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(rst_n[1]), .mem_valid(v[1]), .mem_instr(ins[1]), .mem_addr(ad[1]),
    .mem_wdata(wd[1]), .mem_wstrb(ws[1]), .mem_ready(rdy[1]), .mem_rdata(rd[1]),
    .console_valid(cv[1]), .console_data(cd[1]), .halt(hl[1]), .fault(ft[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int waits(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input int d, input logic i_ins, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, output logic [31:0] e_rd, output logic e_cv,
                       output bit e_rd_ok);
    int wi;
    e_cv = 1'b0;
    e_rd = '0;
    e_rd_ok = (s == 4'b0000);
    if (a < 32'(DEPTH * 4)) begin
      wi = int'(a >> 2);
      e_rd = m_mem[d][wi];
      e_rd_ok = e_rd_ok && (m_known[d][wi] == 4'hF);
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          m_mem[d][wi][8*i +: 8] = w[8*i +: 8];
          m_known[d][wi][i] = 1'b1;
        end
      end
    end else if (!i_ins && ((a & ~32'h3) == MMIO)) begin
      e_rd = 32'h1;
      if (s[0]) begin
        e_cv = 1'b1;
        m_cd[d] = w[7:0];
      end
    end else if (!i_ins && ((a & ~32'h3) == MMIO + 32'h4)) begin
      e_rd = {31'b0, m_halt[d]};
      if (s != 4'b0000) m_halt[d] = 1'b1;
    end else begin
      e_rd = '0;
      e_rd_ok = 1'b1;
      m_fault[d] = 1'b1;
    end
  endtask

  task automatic check_state(input int d, input string tag);
    chk({tag, ":console_data"}, 32'(cd[d]), 32'(m_cd[d]));
    chk({tag, ":halt"}, 32'(hl[d]), 32'(m_halt[d]));
    chk({tag, ":fault"}, 32'(ft[d]), 32'(m_fault[d]));
  endtask

  // One complete transaction; starts and ends #1 after a rising edge with the DUT in IDLE.
  task automatic access(input int d, input logic i_ins, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] s, input string tag, output logic [31:0] obs);
    logic [31:0] e_rd;
    logic        e_cv;
    bit          e_ok;
    bit          got;
    int          n;
    model(d, i_ins, a, w, s, e_rd, e_cv, e_ok);
    ins[d] = i_ins; ad[d] = a; wd[d] = w; ws[d] = s; v[d] = 1'b1;
    n = 0;
    got = 1'b0;
    obs = '0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy[d]) got = 1'b1;
    end
    chk({tag, ":latency"}, 32'(n - 1), 32'(waits(d) + 1));
    if (got) begin
      obs = rd[d];
      if (e_ok) chk({tag, ":rdata"}, rd[d], e_rd);
      chk({tag, ":console_valid"}, 32'(cv[d]), 32'(e_cv));
      check_state(d, tag);
    end
    v[d] = 1'b0;
    @(posedge clk); #1;
    chk({tag, ":ready_pulse"}, {31'b0, rdy[d]} | {31'b0, cv[d]}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a, w;
    logic [3:0]  s;
    int          cnt_rdy;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        m_mem[d][i] = '0;
        m_known[d][i] = 4'h0;
      end
      m_halt[d] = 1'b0; m_fault[d] = 1'b0; m_cd[d] = '0;
      rst_n[d] = 1'b0; v[d] = 1'b0; ins[d] = 1'b0; ad[d] = '0; wd[d] = '0; ws[d] = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset:ready", 32'(rdy[d]), 32'h0);
      chk("reset:rdata", rd[d], 32'h0);
      chk("reset:console_valid", 32'(cv[d]), 32'h0);
      check_state(d, "reset");
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // Full-word write then read back
    access(0, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'b1111, "wr40", obs);
    access(0, 1'b0, 32'h40, 32'h0, 4'b0000, "rd40", obs);
    chk("rd40:const", obs, 32'hDEAD_BEEF);

    // Byte-lane merging
    access(0, 1'b0, 32'h80, 32'h1122_3344, 4'b1111, "wr80", obs);
    access(0, 1'b0, 32'h80, 32'h0000_00AA, 4'b0001, "wr80_b0", obs);
    access(0, 1'b0, 32'h82, 32'h00BB_0000, 4'b0100, "wr80_b2", obs);
    access(0, 1'b0, 32'h80, 32'h0, 4'b0000, "rd80", obs);
    chk("rd80:const", obs, 32'h11BB_33AA);

    // Console and halt MMIO
    access(0, 1'b0, MMIO, 32'h0000_0041, 4'b0001, "con_wr", obs);
    chk("con_wr:data_const", 32'(cd[0]), 32'h41);
    access(0, 1'b0, MMIO, 32'h0, 4'b0000, "con_rd", obs);
    access(0, 1'b0, MMIO + 32'h4, 32'h0, 4'b0000, "halt_rd0", obs);
    access(0, 1'b0, MMIO + 32'h4, 32'h5, 4'b0010, "halt_wr", obs);
    access(0, 1'b0, MMIO + 32'h4, 32'h0, 4'b0000, "halt_rd1", obs);

    // Illegal accesses still answered, fault sticky
    access(0, 1'b0, 32'h0200_0000, 32'h0, 4'b0000, "ill_rd", obs);
    access(0, 1'b1, MMIO, 32'h0, 4'b0000, "ill_fetch", obs);
    access(0, 1'b0, 32'h0200_0000, 32'h1234_5678, 4'b1111, "ill_wr", obs);
    access(0, 1'b1, 32'h40, 32'h0, 4'b0000, "fetch40", obs);
    access(0, 1'b0, 32'h0000_1000, 32'h0, 4'b0000, "ram_edge", obs);

    // Randomized RAM traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++)
        access(d, 1'b0, 32'h100 + 32'(i * 4), $urandom, 4'b1111, "rnd_init", obs);
      for (int i = 0; i < 30; i++) begin
        a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        w = $urandom;
        s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        access(d, 1'(($urandom_range(0, 3) == 0) && s == 4'b0000), a, w, s, "rnd", obs);
      end
    end

    // Abort: drop valid while waiting on a write
    access(1, 1'b0, 32'h200, 32'hCAFE_F00D, 4'b1111, "ab_init", obs);
    ins[1] = 1'b0; ad[1] = 32'h200; wd[1] = 32'h0BAD_0BAD; ws[1] = 4'b1111; v[1] = 1'b1;
    cnt_rdy = 0;
    repeat (2) begin @(posedge clk); #1; if (rdy[1]) cnt_rdy++; end
    v[1] = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rdy[1]) cnt_rdy++; end
    chk("abort:no_ready", 32'(cnt_rdy), 32'h0);
    check_state(1, "abort");
    access(1, 1'b0, 32'h200, 32'h0, 4'b0000, "abort_rd", obs);
    chk("abort_rd:const", obs, 32'hCAFE_F00D);

    // Reset landing on the response edge of a write
    access(1, 1'b0, MMIO, 32'h0000_005A, 4'b0001, "pre_con", obs);
    access(1, 1'b0, MMIO + 32'h4, 32'h1, 4'b1111, "pre_halt", obs);
    access(1, 1'b0, 32'h0300_0000, 32'h0, 4'b0000, "pre_fault", obs);
    ins[1] = 1'b0; ad[1] = 32'h200; wd[1] = 32'h1111_2222; ws[1] = 4'b1111; v[1] = 1'b1;
    cnt_rdy = 0;
    repeat (4) begin @(posedge clk); #1; if (rdy[1]) cnt_rdy++; end
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    m_halt[1] = 1'b0; m_fault[1] = 1'b0; m_cd[1] = '0;
    chk("rst_mid:ready", 32'(rdy[1]), 32'h0);
    chk("rst_mid:rdata", rd[1], 32'h0);
    chk("rst_mid:console_valid", 32'(cv[1]), 32'h0);
    check_state(1, "rst_mid");
    rst_n[1] = 1'b1; v[1] = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (rdy[1]) cnt_rdy++; end
    chk("rst_mid:no_ready", 32'(cnt_rdy), 32'h0);
    access(1, 1'b0, 32'h200, 32'h0, 4'b0000, "rst_rd", obs);
    chk("rst_rd:const", obs, 32'hCAFE_F00D);
    access(1, 1'b0, MMIO, 32'h0000_0033, 4'b0001, "post_con", obs);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
